// File: rtl/modport_ram.sv
// Dual-port RAM: one synchronous write port, one registered read port, async active-low reset.
// Define MODPORT_RAM_BYPASS_EN for write-first collisions; read-first by default.
module modport_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_dout_q, rd_dout_d;
  logic                  rd_valid_q;
  logic                  collision;

  assign collision = we && re && (wr_addr == rd_addr);

  // Memory is built from resettable flops so reset clears every word at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[wr_addr] <= wr_din;
    end
  end

  always_comb begin
    rd_dout_d = rd_dout_q;
    if (re) begin
`ifdef MODPORT_RAM_BYPASS_EN
      rd_dout_d = collision ? wr_din : mem_q[rd_addr];
`else
      // Read-first: the flop array still holds the pre-write word on a collision.
      rd_dout_d = mem_q[rd_addr];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_dout_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_dout_q  <= rd_dout_d;
      rd_valid_q <= re;
    end
  end

`ifndef MODPORT_RAM_BYPASS_EN
  logic unused_collision;
  assign unused_collision = collision;
`endif

  assign rd_dout  = rd_dout_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_modport_ram.sv
// Self-checking bench for modport_ram: directed scenarios plus random traffic against an array model.
module tb_modport_ram;

  logic       clk;
  logic       rst;
  logic       we;
  logic [3:0] wr_addr;
  logic [7:0] wr_din;
  logic       re;
  logic [3:0] rd_addr;
  logic [7:0] rd_dout;
  logic       rd_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [16];
  logic [7:0] m_dout;
  logic       m_valid;

  modport_ram #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_din  (wr_din),
    .re      (re),
    .rd_addr (rd_addr),
    .rd_dout (rd_dout),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock edge of traffic and advance the model by the same rules the RAM must obey.
  task automatic cycle(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                       input logic r, input logic [3:0] ra);
    we = w; wr_addr = wa; wr_din = wd; re = r; rd_addr = ra;
    if (r) begin
`ifdef MODPORT_RAM_BYPASS_EN
      m_dout = (w && wa == ra) ? wd : m_mem[ra];
`else
      m_dout = m_mem[ra];
`endif
    end
    m_valid = r;
    if (w) m_mem[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_dout  = 8'h00;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 4'd9, 8'hC3, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
    checks++;
    if (rd_dout !== 8'hC3) begin
      errors++; $display("FAIL reset_pre_data got=%h want=%h", rd_dout, 8'hC3);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rd_dout !== 8'h00 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_async got=%h/%b want=00/0", rd_dout, rd_valid);
    end
    we = 1'b0; re = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
      checks++;
      if (rd_dout !== 8'h00 || rd_valid !== 1'b1) begin
        errors++; $display("FAIL reset_clear addr=%0d got=%h/%b want=00/1", i, rd_dout, rd_valid);
      end
    end
  endtask

  task automatic test_write_read();
    cycle(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    checks++;
    if (rd_dout !== 8'hA5 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL write_read got=%h/%b want=a5/1", rd_dout, rd_valid);
    end
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd3);
    checks++;
    if (rd_dout !== 8'hA5 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL hold got=%h/%b want=a5/0", rd_dout, rd_valid);
    end
  endtask

  task automatic test_parallel();
    cycle(1'b1, 4'd7, 8'h11, 1'b0, 4'd0);
    cycle(1'b1, 4'd2, 8'h22, 1'b1, 4'd7);
    checks++;
    if (rd_dout !== 8'h11 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL parallel_rd7 got=%h/%b want=11/1", rd_dout, rd_valid);
    end
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
    checks++;
    if (rd_dout !== 8'h22) begin
      errors++; $display("FAIL parallel_rd2 got=%h want=22", rd_dout);
    end
  endtask

  task automatic test_collision();
    logic [7:0] want;
`ifdef MODPORT_RAM_BYPASS_EN
    want = 8'h44;
`else
    want = 8'h33;
`endif
    cycle(1'b1, 4'd5, 8'h33, 1'b0, 4'd0);
    cycle(1'b1, 4'd5, 8'h44, 1'b1, 4'd5);
    checks++;
    if (rd_dout !== want) begin
      errors++; $display("FAIL collision got=%h want=%h", rd_dout, want);
    end
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    checks++;
    if (rd_dout !== 8'h44) begin
      errors++; $display("FAIL collision_after got=%h want=44", rd_dout);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 8'(i) ^ 8'h5A, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
      checks++;
      if (rd_dout !== (8'(i) ^ 8'h5A) || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep addr=%0d got=%h/%b want=%h/1", i, rd_dout, rd_valid, 8'(i) ^ 8'h5A);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    checks++;
    if (rd_dout !== 8'hA5 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre got=%h/%b want=a5/1", rd_dout, rd_valid);
    end
    #2 rst = 1'b0;
    model_reset();
    // Traffic held active through reset must be ignored.
    we = 1'b1; wr_addr = 4'd3; wr_din = 8'hFF; re = 1'b1; rd_addr = 4'd3;
    #1;
    checks++;
    if (rd_dout !== 8'h00 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async got=%h/%b want=00/0", rd_dout, rd_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_dout !== 8'h00 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_hold got=%h/%b want=00/0", rd_dout, rd_valid);
    end
    we = 1'b0; re = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    checks++;
    if (rd_dout !== 8'h00 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_rd3 got=%h/%b want=00/1", rd_dout, rd_valid);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom));
      checks++;
      if (rd_dout !== m_dout || rd_valid !== m_valid) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL random n=%0d got=%h/%b want=%h/%b", n, rd_dout, rd_valid, m_dout, m_valid);
      end
    end
  endtask

  initial begin
    we = 1'b0; wr_addr = '0; wr_din = '0; re = 1'b0; rd_addr = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_parallel();
    test_collision();
    test_sweep();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modport_ram.md
MODPORT_RAM -- requirements
Module: modport_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: address width; depth SHALL be 2**ADDR_WIDTH words (16 by default).
REQ-002 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-003 clk  input  1: single clock; all sequential logic SHALL be on its rising edge.
REQ-004 rst  input  1: reset, asynchronous assert, active-low (0 = reset).
REQ-005 we  input  1: write enable, active high.
REQ-006 wr_addr  input  ADDR_WIDTH: write address.
REQ-007 wr_din  input  DATA_WIDTH: write data.
REQ-008 re  input  1: read enable, active high.
REQ-009 rd_addr  input  ADDR_WIDTH: read address.
REQ-010 rd_dout  output  DATA_WIDTH: registered read data.
REQ-011 rd_valid  output  1: high for exactly the cycle in which rd_dout carries data from a read accepted on the previous edge.

Function
REQ-012 Write: on a rising edge with rst=1 and we=1, mem[wr_addr] SHALL take wr_din; we=0 SHALL leave memory unchanged.
REQ-013 Read: on a rising edge with rst=1 and re=1, rd_dout SHALL take mem[rd_addr]; read latency is one cycle.
REQ-014 rd_dout SHALL hold its last value on edges with re=0.
REQ-015 rd_valid SHALL be registered re: 1 after an edge with re=1, 0 after an edge with re=0.
REQ-016 Write and read ports are independent; we=1 and re=1 on the same edge at different addresses SHALL both complete.
REQ-017 Same-edge collision (we=1, re=1, wr_addr==rd_addr): rd_dout behaviour is set by REQ-023/REQ-024; memory SHALL always take wr_din.
REQ-018 Every address 0..2**ADDR_WIDTH-1 is valid; no wrap logic or error output exists.
REQ-019 Inputs are sampled only at the rising edge; no combinational path from any input to rd_dout or rd_valid.

Reset
REQ-020 rst=0 SHALL immediately, without waiting for clk, clear rd_dout to 0, rd_valid to 0 and every memory word to 0.
REQ-021 While rst=0, we and re SHALL be ignored; a reset asserted mid-operation discards any in-flight read and any write on that edge.
REQ-022 The first rising edge with rst=1 SHALL behave per REQ-012..REQ-017.

Configuration
REQ-023 With macro MODPORT_RAM_BYPASS_EN defined, a same-edge collision SHALL return the new data (wr_din) on rd_dout (write-first).
REQ-024 Without MODPORT_RAM_BYPASS_EN, a same-edge collision SHALL return the pre-write memory contents (read-first); all other behaviour is identical.

Verification
REQ-025 Reset: rst=0 asynchronously mid-cycle -> rd_dout=0x00 and rd_valid=0 before the next edge; then read each of the 16 addresses -> every rd_dout=0x00.
REQ-026 Write/read: write 0xA5 to addr 3, then re=1 rd_addr=3 on the next edge -> one cycle later rd_dout=0xA5 and rd_valid=1; next edge with re=0 -> rd_dout stays 0xA5 and rd_valid=0.
REQ-027 Parallel ports: mem[7]=0x11; on the same edge write 0x22 to addr 2 and read addr 7 -> rd_dout=0x11; then read addr 2 -> 0x22.
REQ-028 Collision: mem[5]=0x33; on the same edge write 0x44 to addr 5 and read addr 5 -> rd_dout=0x44 with MODPORT_RAM_BYPASS_EN, 0x33 without; a following read of addr 5 -> 0x44 in both builds.
REQ-029 Full sweep: write addr^0x5A to each of addresses 0..15 in turn, then read back 0..15 with re=1 on every edge -> each word matches and rd_valid stays 1 on all 16 result cycles.
REQ-030 Reset mid-operation: assert rst=0 in the cycle after a read of addr 3 (holding 0xA5) is accepted -> rd_dout=0x00 and rd_valid=0; after release, a read of addr 3 -> 0x00.
